// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU writeback (A)
// and load/mul-div writeback (B), with in-flight forwarding hits and a conflict counter.
module regfile_write_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             AValid,
    input  logic [4:0]       AAddr,
    input  logic [31:0]      AData,
    output logic             AReady,
    input  logic             BValid,
    input  logic [4:0]       BAddr,
    input  logic [31:0]      BData,
    output logic             BReady,
    output logic             RegWrite,
    output logic [4:0]       WriteAddr,
    output logic [31:0]      WriteData,
    input  logic [4:0]       ReadAddr1,
    input  logic [4:0]       ReadAddr2,
    output logic             FwdHit1,
    output logic             FwdHit2,
    output logic [31:0]      FwdData,
    output logic [CNT_W-1:0] ConflictCount
);

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    logic             a_nz_s;
    logic             b_nz_s;
    logic             a_zero_s;
    logic             b_zero_s;
    logic             grant_a_s;
    logic             grant_b_s;

    grant_e           last_grant_q;
    grant_e           last_grant_d;
    logic             reg_write_q;
    logic             reg_write_d;
    logic [4:0]       waddr_q;
    logic [4:0]       waddr_d;
    logic [31:0]      wdata_q;
    logic [31:0]      wdata_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign a_nz_s   = AValid && (AAddr != 5'd0);
    assign b_nz_s   = BValid && (BAddr != 5'd0);
    assign a_zero_s = AValid && (AAddr == 5'd0);
    assign b_zero_s = BValid && (BAddr == 5'd0);

    // Grant selection: only non-zero requests compete; ties go to the requester not granted last.
    always_comb begin
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        if (Reset) begin
            grant_a_s = 1'b0;
            grant_b_s = 1'b0;
        end else if (a_nz_s && b_nz_s) begin
            if (last_grant_q == GRANT_B) begin
                grant_a_s = 1'b1;
            end else begin
                grant_b_s = 1'b1;
            end
        end else begin
            grant_a_s = a_nz_s;
            grant_b_s = b_nz_s;
        end
    end

    // Zero-address requests are swallowed immediately so they never stall the requester.
    assign AReady = !Reset && (a_zero_s || grant_a_s);
    assign BReady = !Reset && (b_zero_s || grant_b_s);

    // Next-state for the output stage, round-robin pointer and conflict counter.
    always_comb begin
        reg_write_d  = 1'b0;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        if (grant_a_s) begin
            reg_write_d  = 1'b1;
            waddr_d      = AAddr;
            wdata_d      = AData;
            last_grant_d = GRANT_A;
        end else if (grant_b_s) begin
            reg_write_d  = 1'b1;
            waddr_d      = BAddr;
            wdata_d      = BData;
            last_grant_d = GRANT_B;
        end else begin
            reg_write_d  = 1'b0;
        end
        if (a_nz_s && b_nz_s && !Reset) begin
            cnt_d = sat_inc(cnt_q);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers; reset leaves B as last winner so A takes the first tie.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            reg_write_q  <= 1'b0;
            waddr_q      <= 5'd0;
            wdata_q      <= 32'd0;
            last_grant_q <= GRANT_B;
            cnt_q        <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    assign RegWrite      = reg_write_q;
    assign WriteAddr     = waddr_q;
    assign WriteData     = wdata_q;
    assign FwdData       = wdata_q;
    // WriteAddr is never 0 while RegWrite is set, so register 0 can never hit.
    assign FwdHit1       = reg_write_q && (waddr_q == ReadAddr1);
    assign FwdHit2       = reg_write_q && (waddr_q == ReadAddr2);
    assign ConflictCount = cnt_q;

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single register-file write port between two writeback requesters: requester A (ALU writeback) and requester B (load / multiply-divide result). Both use a valid/ready handshake. The block grants one non-zero-address request per cycle by round-robin and registers the winner onto the register file's `RegWrite`/`WriteAddr`/`WriteData` inputs. It also flags read addresses that hit the write currently in flight, so the datapath can forward, and it counts write-port conflict cycles for performance debug.

## Interface
- `CNT_W`, default 16: width of the saturating conflict counter.
- `Clock`, input, 1: single clock; all state updates on the rising edge.
- `Reset`, input, 1: synchronous, active-high reset.
- `AValid`, input, 1: requester A has a write pending.
- `AAddr`, input, 5: A destination register.
- `AData`, input, 32: A write data.
- `AReady`, output, 1: A request accepted this cycle (combinational).
- `BValid`, input, 1: requester B has a write pending.
- `BAddr`, input, 5: B destination register.
- `BData`, input, 32: B write data.
- `BReady`, output, 1: B request accepted this cycle (combinational).
- `RegWrite`, output, 1: registered write enable to the register file.
- `WriteAddr`, output, 5: registered write address.
- `WriteData`, output, 32: registered write data.
- `ReadAddr1`, input, 5: register-file read address, port 1.
- `ReadAddr2`, input, 5: register-file read address, port 2.
- `FwdHit1`, output, 1: in-flight write targets `ReadAddr1`.
- `FwdHit2`, output, 1: in-flight write targets `ReadAddr2`.
- `FwdData`, output, 32: data of the in-flight write (equal to `WriteData`).
- `ConflictCount`, output, `CNT_W`: saturating count of contended cycles.

## Operation
- **Handshake.** A transfer occurs when `xValid && xReady` in the same cycle. `xReady` may depend on both valids and must never depend on `xData`. Requesters hold their address and data stable until the transfer occurs.
- **Address 0.**
  - A valid request with `xAddr == 0` is accepted immediately (`xReady = 1`), independent of the other requester.
  - It is discarded and produces no `RegWrite`.
  - It does not update the priority pointer and does not count as contention.
- **Arbitration (non-zero addresses only).**
  - If exactly one requester is valid, it is granted.
  - If both are valid, the requester other than `LastGrant` wins and the loser's `xReady` stays 0.
  - `LastGrant` is updated to the winner on every non-zero grant.
- **Same destination address in both requests.** No merging. The two writes are issued in consecutive grant cycles, in round-robin order.
- **Output stage.**
  - On a non-zero grant in cycle N, `RegWrite=1`, `WriteAddr`, and `WriteData` take the winner's values at the end of cycle N.
  - With no non-zero grant, `RegWrite=0` next cycle. `WriteAddr` and `WriteData` hold their last values.
  - `WriteAddr` is never 0 while `RegWrite=1`.
- **Forwarding.**
  - `FwdHit1 = RegWrite && (WriteAddr == ReadAddr1)`; `FwdHit2` is the same against `ReadAddr2`. Both are combinational.
  - `FwdData = WriteData`.
  - A read of register 0 never hits.
- **ConflictCount.**
  - Increments by 1 at the end of each cycle in which both `AValid && AAddr != 0` and `BValid && BAddr != 0` are true.
  - Saturates at `2^CNT_W - 1`.

## Timing
- **Handshake to write.** Latency is 1 cycle. A request granted in cycle N appears as `RegWrite=1` in cycle N+1. The register file commits it at the end of cycle N+1.
- **Throughput.** One non-zero write per cycle. Each requester gets at least every other cycle under continuous contention.
- **Reset.** While `Reset` is high, `AReady=0` and `BReady=0` (combinational override).
- **Values after a `Reset` edge:**
  - `RegWrite=0`, `WriteAddr=0`, `WriteData=0`.
  - `FwdHit1=0`, `FwdHit2=0`.
  - `ConflictCount=0`.
  - `LastGrant=B`, so A wins the first tie.
  - `ConflictCount` does not count during reset cycles.
- **Reset mid-operation.** A write held in the output stage is dropped (`RegWrite=0` after the edge). Requests presented during reset are not accepted and must be held by the requester.
- **Simultaneous events.**
  - A zero-address request from one requester and a non-zero request from the other are both accepted in the same cycle.
  - A new grant in the same cycle as an outstanding `RegWrite` simply replaces the output stage next cycle; no bubble is required.

## Test plan
- **Reset.** Assert `Reset` 2 cycles with `AValid=BValid=1` → `AReady=BReady=0`, `RegWrite=0`, `WriteAddr=0`, `ConflictCount=0`.
- **Single requester.** `AValid=1`, `AAddr=5`, `AData=32'hDEADBEEF` for one cycle → `AReady=1` that cycle; next cycle `RegWrite=1`, `WriteAddr=5`, `WriteData=32'hDEADBEEF`; the cycle after, `RegWrite=0`.
- **Contention with same address.** After reset, both valid: A (`AAddr=3`, `AData=1`), B (`BAddr=3`, `BData=2`), each held until accepted.
  - Cycle 0: A granted. Cycle 1: B granted.
  - `RegWrite` sequence: addr 3 / data 1, then addr 3 / data 2.
  - `ConflictCount=1`.
- **Zero address alongside a real write.** `AValid`, `AAddr=0` and `BValid`, `BAddr=7`, `BData=9` in the same cycle → `AReady=BReady=1`; next cycle a single write, addr 7 / data 9.
- **Forwarding.** While `RegWrite=1` with `WriteAddr=12` and `WriteData=32'h55`, drive `ReadAddr1=12` and `ReadAddr2=13` → `FwdHit1=1`, `FwdHit2=0`, `FwdData=32'h55`. With `ReadAddr1=0` → `FwdHit1=0`.
- **Saturation and fairness.** With `CNT_W=2`, hold both valid with non-zero addresses for 10 cycles.
  - Grants alternate A, B, A, B, and so on.
  - `ConflictCount` reaches 3 and holds at 3.
  - Reset mid-burst → `RegWrite=0` after the edge and `ConflictCount=0`.
